// File: rtl/mux_scan_sequencer_if.sv
// Signal bundle between the mux scan sequencer, the 8-to-1 mux it drives and the byte consumer.
// master = sequencer side, slave = mux/consumer side.
interface mux_scan_sequencer_if;
   logic       start;
   logic       mux_o;
   logic       s0;
   logic       s1;
   logic       s2;
   logic       busy;
   logic [7:0] data;
   logic       data_valid;
   logic       data_ack;
   logic       parity;

   modport master (
      input  start, mux_o, data_ack,
      output s0, s1, s2, busy, data, data_valid, parity
   );

   modport slave (
      output start, mux_o, data_ack,
      input  s0, s1, s2, busy, data, data_valid, parity
   );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Walks the 8-to-1 mux select through all positions, samples each output and hands the byte downstream.
// Optional parity of the captured byte is enabled with `define MUX_SCAN_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for start; select lines hold their last value
// SETTLE | select driven, waiting SETTLE_CYCLES for the mux output to settle
// SAMPLE | capture mux_o into data[index], then advance or finish
// DONE   | byte valid, held until data_ack
module mux_scan_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter bit          MSB_FIRST     = 1'b0
) (
   input logic                  clk,
   input logic                  rst,
   mux_scan_sequencer_if.master bus
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [2:0] FIRST_IDX = MSB_FIRST ? 3'd7 : 3'd0;
   localparam logic [2:0] LAST_IDX  = MSB_FIRST ? 3'd0 : 3'd7;
   localparam logic [3:0] CNT_LAST  = 4'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;

`ifdef MUX_SCAN_PARITY_EN
   logic parity_q, parity_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 3'd0;
         cnt_q   <= 4'd0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
`ifdef MUX_SCAN_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
`ifdef MUX_SCAN_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               idx_d   = FIRST_IDX;
               cnt_d   = 4'd0;
               data_d  = 8'h00;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) state_d = SAMPLE;
         end
         SAMPLE: begin
            data_d[idx_q] = bus.mux_o;
            if (idx_q == LAST_IDX) begin
               valid_d = 1'b1;
               state_d = DONE;
`ifdef MUX_SCAN_PARITY_EN
               parity_d = ^data_d;
`endif
            end else begin
               // index stops at the last position, so it never wraps
               idx_d   = MSB_FIRST ? idx_q - 3'd1 : idx_q + 3'd1;
               cnt_d   = 4'd0;
               state_d = SETTLE;
            end
         end
         DONE: begin
            if (bus.data_ack) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.s0         = idx_q[2];
   assign bus.s1         = idx_q[1];
   assign bus.s2         = idx_q[0];
   assign bus.busy       = (state_q != IDLE);
   assign bus.data       = data_q;
   assign bus.data_valid = valid_q;

`ifdef MUX_SCAN_PARITY_EN
   assign bus.parity = parity_q;
`else
   assign bus.parity = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: instance A uses defaults, instance B uses MSB_FIRST=1, SETTLE_CYCLES=3.
// A behavioural model predicts every output each cycle; directed scenarios pin the model with literals.
module tb_mux_scan_sequencer;

   localparam int SET_A = 1;
   localparam int SET_B = 3;

   logic clk;
   logic rst;
   logic chk_en;
   int   n_cmp;
   int   n_mis;

   logic [7:0] mux_in  [2];
   logic       start_v [2];
   logic       ack_v   [2];

   mux_scan_sequencer_if ifa();
   mux_scan_sequencer_if ifb();

   mux_scan_sequencer #(.SETTLE_CYCLES(SET_A), .MSB_FIRST(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   mux_scan_sequencer #(.SETTLE_CYCLES(SET_B), .MSB_FIRST(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   // the mux itself: index = {s0,s1,s2}
   assign ifa.mux_o    = mux_in[0][{ifa.s0, ifa.s1, ifa.s2}];
   assign ifb.mux_o    = mux_in[1][{ifb.s0, ifb.s1, ifb.s2}];
   assign ifa.start    = start_v[0];
   assign ifb.start    = start_v[1];
   assign ifa.data_ack = ack_v[0];
   assign ifb.data_ack = ack_v[1];

   logic [2:0] d_sel   [2];
   logic       d_busy  [2];
   logic [7:0] d_data  [2];
   logic       d_valid [2];
   logic       d_par   [2];

   assign d_sel[0]   = {ifa.s0, ifa.s1, ifa.s2};
   assign d_sel[1]   = {ifb.s0, ifb.s1, ifb.s2};
   assign d_busy[0]  = ifa.busy;
   assign d_busy[1]  = ifb.busy;
   assign d_data[0]  = ifa.data;
   assign d_data[1]  = ifb.data;
   assign d_valid[0] = ifa.data_valid;
   assign d_valid[1] = ifb.data_valid;
   assign d_par[0]   = ifa.parity;
   assign d_par[1]   = ifb.parity;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int settle_of(int i);
      return (i == 0) ? SET_A : SET_B;
   endfunction

   // position p (0..7) of the scan order -> mux index
   function automatic int order(int i, int p);
      return (i == 0) ? p : 7 - p;
   endfunction

   task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
      end
   endtask

   // model: edges elapsed since start-accept determine position and capture points
   int         m_e     [2];
   bit         m_busy  [2];
   bit         m_done  [2];
   bit         m_valid [2];
   logic [2:0] m_sel   [2];
   logic [7:0] m_data  [2];
   logic       m_par   [2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_busy[i] = 0; m_done[i] = 0; m_valid[i] = 0;
            m_sel[i] = 3'd0; m_data[i] = 8'h00; m_par[i] = 1'b0; m_e[i] = 0;
         end else if (!m_busy[i]) begin
            if (start_v[i]) begin
               m_busy[i] = 1; m_e[i] = 0;
               m_sel[i] = 3'(order(i, 0)); m_data[i] = 8'h00;
            end
         end else if (m_done[i]) begin
            if (ack_v[i]) begin
               m_done[i] = 0; m_busy[i] = 0; m_valid[i] = 0;
            end
         end else begin
            m_e[i]++;
            if (m_e[i] % (settle_of(i) + 1) == 0) begin
               int p, k;
               p = m_e[i] / (settle_of(i) + 1) - 1;
               k = order(i, p);
               m_data[i][k] = mux_in[i][k];
               if (p == 7) begin
                  m_done[i] = 1; m_valid[i] = 1;
`ifdef MUX_SCAN_PARITY_EN
                  m_par[i] = ^m_data[i];
`endif
               end else begin
                  m_sel[i] = 3'(order(i, p + 1));
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk("sel",    i, 32'(d_sel[i]),   32'(m_sel[i]));
            chk("busy",   i, 32'(d_busy[i]),  32'(m_busy[i]));
            chk("data",   i, 32'(d_data[i]),  32'(m_data[i]));
            chk("valid",  i, 32'(d_valid[i]), 32'(m_valid[i]));
            chk("parity", i, 32'(d_par[i]),   32'(m_par[i]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // pulse start, return edges from accept until data_valid (bounded)
   task automatic run_scan(int i, bit noisy, output int n);
      start_v[i] = 1'b1;
      tick();
      start_v[i] = 1'b0;
      n = 0;
      while (!d_valid[i] && n < 300) begin
         if (noisy) begin
            start_v[i] = ($urandom_range(2, 0) == 0);
            ack_v[i]   = ($urandom_range(2, 0) == 0);
            if ($urandom_range(3, 0) == 0) mux_in[i][$urandom_range(7, 0)] ^= 1'b1;
         end
         tick();
         n++;
      end
      start_v[i] = 1'b0;
      ack_v[i]   = 1'b0;
      if (n >= 300) chk("scan_timeout", i, 32'(n), 32'(8 * (settle_of(i) + 1)));
   endtask

   task automatic ack_now(int i);
      ack_v[i] = 1'b1;
      tick();
      ack_v[i] = 1'b0;
   endtask

   int         n;
   logic       exp_par;

   initial begin
      n_cmp = 0; n_mis = 0; chk_en = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start_v[i] = 1'b0; ack_v[i] = 1'b0; mux_in[i] = 8'h00;
      end
      repeat (3) tick();
      rst = 1'b0;
      chk_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_sel",   i, 32'(d_sel[i]),   32'd0);
         chk("rst_data",  i, 32'(d_data[i]),  32'h00);
         chk("rst_valid", i, 32'(d_valid[i]), 32'd0);
         chk("rst_busy",  i, 32'(d_busy[i]),  32'd0);
         chk("rst_par",   i, 32'(d_par[i]),   32'd0);
      end

      // LSB-first default scan of A5
      mux_in[0] = 8'hA5;
      run_scan(0, 1'b0, n);
      chk("t1_latency", 0, 32'(n), 32'd16);
      chk("t1_data",    0, 32'(d_data[0]), 32'hA5);
      chk("t1_parity",  0, 32'(d_par[0]),  32'd0);
      ack_now(0);

      // MSB-first, 3 settle cycles, 07
      mux_in[1] = 8'h07;
      run_scan(1, 1'b0, n);
      chk("t2_latency", 1, 32'(n), 32'd32);
      chk("t2_data",    1, 32'(d_data[1]), 32'h07);
`ifdef MUX_SCAN_PARITY_EN
      exp_par = 1'b1;
`else
      exp_par = 1'b0;
`endif
      chk("t2_parity", 1, 32'(d_par[1]), 32'(exp_par));

      // hold in DONE with start toggling
      for (int c = 0; c < 10; c++) begin
         start_v[1] = c[0];
         tick();
      end
      start_v[1] = 1'b0;
      chk("t3_hold_valid", 1, 32'(d_valid[1]), 32'd1);
      chk("t3_hold_busy",  1, 32'(d_busy[1]),  32'd1);
      chk("t3_hold_data",  1, 32'(d_data[1]),  32'h07);
      ack_now(1);
      chk("t3_ack_valid", 1, 32'(d_valid[1]), 32'd0);
      chk("t3_ack_busy",  1, 32'(d_busy[1]),  32'd0);
      chk("t3_ack_data",  1, 32'(d_data[1]),  32'h07);

      // reset during the 5th SAMPLE (cycle before edge 10 after accept)
      mux_in[0] = 8'hFF;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      repeat (9) tick();
      chk("t4_pre_busy", 0, 32'(d_busy[0]), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4_sel",   0, 32'(d_sel[0]),   32'd0);
      chk("t4_data",  0, 32'(d_data[0]),  32'h00);
      chk("t4_valid", 0, 32'(d_valid[0]), 32'd0);
      chk("t4_busy",  0, 32'(d_busy[0]),  32'd0);
      mux_in[0] = 8'h3C;
      run_scan(0, 1'b0, n);
      chk("t4_latency", 0, 32'(n), 32'd16);
      chk("t4_data2",   0, 32'(d_data[0]), 32'h3C);
      ack_now(0);

      // start re-pulsed mid-scan, then start+ack together in DONE
      mux_in[0] = 8'h5A;
      start_v[0] = 1'b1;
      tick();
      n = 0;
      while (!d_valid[0] && n < 300) begin
         start_v[0] = (n % 3 == 1);
         tick();
         n++;
      end
      start_v[0] = 1'b0;
      chk("t5_latency", 0, 32'(n), 32'd16);
      chk("t5_data",    0, 32'(d_data[0]), 32'h5A);
      start_v[0] = 1'b1;
      ack_v[0]   = 1'b1;
      tick();
      start_v[0] = 1'b0;
      ack_v[0]   = 1'b0;
      repeat (2) tick();
      chk("t5_no_restart", 0, 32'(d_busy[0]),  32'd0);
      chk("t5_valid_low",  0, 32'(d_valid[0]), 32'd0);

      // input changes after vs before their sample edge
      mux_in[0] = 8'h00;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      repeat (6) tick();
      mux_in[0][1] = 1'b1;
      mux_in[0][5] = 1'b1;
      n = 6;
      while (!d_valid[0] && n < 300) begin
         tick();
         n++;
      end
      chk("t6_latency", 0, 32'(n), 32'd16);
      chk("t6_data",    0, 32'(d_data[0]), 32'h20);
      ack_now(0);

      // randomized scans on both instances
      for (int it = 0; it < 24; it++) begin
         int i;
         i = it % 2;
         mux_in[i] = 8'($urandom);
         run_scan(i, 1'b1, n);
         chk("rnd_latency", i, 32'(n), 32'(8 * (settle_of(i) + 1)));
         repeat ($urandom_range(4, 0)) begin
            start_v[i] = ($urandom_range(1, 0) == 1);
            tick();
         end
         start_v[i] = ($urandom_range(1, 0) == 1);
         ack_now(i);
         start_v[i] = 1'b0;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
